// File: rtl/mov_pkg.sv
// Shared definitions for the register-move pipeline: move-mode encodings and op width.
package mov_pkg;

    localparam int unsigned MOV_OP_W = 2;

    typedef enum logic [MOV_OP_W-1:0] {
        MOV_OP_MOV = 2'b00,
        MOV_OP_MVN = 2'b01,
        MOV_OP_CLR = 2'b10,
        MOV_OP_SET = 2'b11
    } mov_op_e;

endpackage

// File: rtl/mov_stage.sv
// One pipeline slot of mov_pipe: valid bit plus data (and zero flag when MOV_ZERO_FLAG_EN
// is defined). Loads from the previous slot when adv is high, otherwise holds.
module mov_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
`ifdef MOV_ZERO_FLAG_EN
    input  logic             prev_zero,
    output logic             zero,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Slot register: cleared by reset, loaded on advance, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
`ifdef MOV_ZERO_FLAG_EN
            zero  <= 1'b0;
`endif
        end else if (adv) begin
            valid <= prev_valid;
            data  <= prev_data;
`ifdef MOV_ZERO_FLAG_EN
            zero  <= prev_zero;
`endif
        end
    end

endmodule

// File: rtl/mov_pipe.sv
// WIDTH-bit register-move unit (MOV/MVN/CLR/SET) feeding a DEPTH-stage elastic pipeline with
// valid/ready on both sides. Empty stages collapse even while the output is stalled.
// Optional: define MOV_ZERO_FLAG_EN to add the out_zero flag travelling with each result.
module mov_pipe
    import mov_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [MOV_OP_W-1:0] in_op,
`ifdef MOV_ZERO_FLAG_EN
    output logic                out_zero,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data
);

    logic [WIDTH-1:0] mode_res;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] prev_valid;
    logic [WIDTH-1:0] d          [DEPTH];
    logic [WIDTH-1:0] prev_data  [DEPTH];
`ifdef MOV_ZERO_FLAG_EN
    logic [DEPTH-1:0] z;
    logic [DEPTH-1:0] prev_zero;
`endif

    // Mode function applied ahead of stage 0.
    always_comb begin
        mode_res = in_data;
        case (mov_op_e'(in_op))
            MOV_OP_MOV: mode_res = in_data;
            MOV_OP_MVN: mode_res = ~in_data;
            MOV_OP_CLR: mode_res = '0;
            MOV_OP_SET: mode_res = '1;
            default:    mode_res = in_data;
        endcase
    end

    // Ready ripples back from the output; any empty stage lets everything upstream move.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready | ~v[DEPTH-1];
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~v[i];
        end
    end

    assign in_ready = adv[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign prev_valid[i] = in_valid & in_ready;
            assign prev_data[i]  = mode_res;
`ifdef MOV_ZERO_FLAG_EN
            assign prev_zero[i]  = (mode_res == '0);
`endif
        end else begin : g_body
            assign prev_valid[i] = v[i-1];
            assign prev_data[i]  = d[i-1];
`ifdef MOV_ZERO_FLAG_EN
            assign prev_zero[i]  = z[i-1];
`endif
        end

        mov_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv[i]),
            .prev_valid(prev_valid[i]),
            .prev_data (prev_data[i]),
`ifdef MOV_ZERO_FLAG_EN
            .prev_zero (prev_zero[i]),
            .zero      (z[i]),
`endif
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
`ifdef MOV_ZERO_FLAG_EN
    assign out_zero  = z[DEPTH-1];
`endif

endmodule

// File: tb/tb_mov_pipe.sv
// Scoreboard bench for mov_pipe: the driver pushes reference results when an operand is
// accepted; an independent monitor pops and compares whenever a result is taken.
module tb_mov_pipe;
    import mov_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef MOV_ZERO_FLAG_EN
    logic          out_zero;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    mov_pipe #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
`ifdef MOV_ZERO_FLAG_EN
        .out_zero (out_zero),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_mode(input logic [1:0] op, input logic [W-1:0] d);
        case (op)
            2'd0:    return d;
            2'd1:    return ~d;
            2'd2:    return {W{1'b0}};
            default: return {W{1'b1}};
        endcase
    endfunction

    // One cycle of stimulus; at the falling edge the acceptance is judged against occupancy.
    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] dat,
                         input logic ordy, output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_op     = op;
        in_data   = dat;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < D) || ordy});
        acc = v && in_ready;
        if (acc) begin
            e.data = ref_mode(op, dat);
            e.zero = (e.data == '0);
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, ordy, a);
    endtask

    // Monitor: compares each taken result and checks stability while stalled.
    initial begin
        logic         stall_p;
        logic [W-1:0] data_p;
        exp_t         e;
        stall_p = 1'b0;
        data_p  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stall_p = 1'b0;
            end else begin
                if (stall_p) begin
                    chk("hold_valid", {63'd0, out_valid}, 64'd1);
                    chk("hold_data", {56'd0, out_data}, {56'd0, data_p});
                end
                if (out_valid && out_ready) begin
                    chk("out_expected", {63'd0, q.size() != 0}, 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("out_data", {56'd0, out_data}, {56'd0, e.data});
`ifdef MOV_ZERO_FLAG_EN
                        chk("out_zero", {63'd0, out_zero}, {63'd0, e.zero});
`endif
                    end
                end
                stall_p = out_valid && !out_ready;
                data_p  = out_data;
            end
        end
    end

    initial begin
        logic acc;
        int   n;

        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single MOV: visible exactly D cycles after acceptance
        drive(1'b1, MOV_OP_MOV, 8'hA5, 1'b1, acc);
        chk("t1_accept", {63'd0, acc}, 64'd1);
        for (int k = 1; k <= int'(D); k++) begin
            drive(1'b0, 2'd0, '0, 1'b1, acc);
            chk("t1_latency", {63'd0, out_valid}, {63'd0, k == int'(D)});
            if (k == int'(D)) chk("t1_data", {56'd0, out_data}, 64'hA5);
        end
        idle(D + 1, 1'b1);

        // Back-to-back MVN, CLR, SET: three consecutive valid output cycles
        drive(1'b1, MOV_OP_MVN, 8'h0F, 1'b1, acc);
        drive(1'b1, MOV_OP_CLR, 8'hFF, 1'b1, acc);
        drive(1'b1, MOV_OP_SET, 8'h00, 1'b1, acc);
        for (int k = 1; k <= int'(D) + 2; k++) begin
            drive(1'b0, 2'd0, '0, 1'b1, acc);
            chk("t2_stream", {63'd0, out_valid},
                {63'd0, (2 + k >= int'(D)) && (2 + k <= int'(D) + 2)});
        end
        idle(2, 1'b1);

        // Backpressure: only D of three operands accepted, then drain in order
        n = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, MOV_OP_MOV, W'($urandom), 1'b0, acc);
            n += int'(acc);
        end
        chk("t3_accepts", 64'(n), 64'(D));
        idle(3, 1'b0);
        idle(D + 2, 1'b1);
        chk("t3_drained", 64'(q.size()), 64'd0);

        // Full with simultaneous pop and push keeps occupancy at D
        for (int k = 0; k < int'(D); k++) drive(1'b1, MOV_OP_MVN, W'($urandom), 1'b0, acc);
        drive(1'b1, MOV_OP_SET, 8'h12, 1'b1, acc);
        chk("t4_push_pop", {63'd0, acc}, 64'd1);
        drive(1'b1, MOV_OP_MOV, 8'h34, 1'b0, acc);
        chk("t4_still_full", {63'd0, acc}, 64'd0);
        idle(D + 2, 1'b1);

        // Reset mid-operation discards in-flight results
        for (int k = 0; k < int'(D); k++) drive(1'b1, MOV_OP_MOV, W'($urandom), 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_out_data", {56'd0, out_data}, 64'd0);
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < int'(D) + 3; k++) begin
            drive(1'b0, 2'd0, '0, 1'b1, acc);
            chk("t5_no_stale", {63'd0, out_valid}, 64'd0);
        end

`ifdef MOV_ZERO_FLAG_EN
        // Zero flag follows its result
        drive(1'b1, MOV_OP_MOV, 8'h00, 1'b1, acc);
        drive(1'b1, MOV_OP_MVN, 8'hFF, 1'b1, acc);
        drive(1'b1, MOV_OP_MOV, 8'h01, 1'b1, acc);
        drive(1'b1, MOV_OP_SET, 8'h5A, 1'b1, acc);
        idle(D + 2, 1'b1);
`endif

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), W'($urandom),
                  $urandom_range(0, 9) < 6, acc);
        end

        // Bounded final drain
        for (int k = 0; k < 50 && q.size() != 0; k++) drive(1'b0, 2'd0, '0, 1'b1, acc);
        idle(2, 1'b1);
        chk("final_drain", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
